// File: rtl/edge_debouncer_pkg.sv
// Shared helpers for the edge debouncer: counter-width sizing and the
// integrator step encoding used by every channel.
package edge_debouncer_pkg;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_UP   = 2'd1,
    ACT_DOWN = 2'd2
  } int_act_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, saturating up/down integrator with
// hysteresis, level register and registered rise/fall pulses.
module debounce_channel
  import edge_debouncer_pkg::*;
#(
  parameter int unsigned pulse_count_max          = 150,
  parameter int unsigned sync_stages              = 2,
  parameter int unsigned saturating_counter_width = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic glitchy_signal,
  output logic debounced_signal,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [saturating_counter_width-1:0] CNT_MAX =
    saturating_counter_width'(pulse_count_max);

  logic [sync_stages-1:0]              sync_q;
  logic [saturating_counter_width-1:0] cnt_q, cnt_d;
  logic                                level_q, level_d;
  logic                                rise_q, fall_q;
  logic                                s;
  int_act_t                            act;

  assign s = sync_q[sync_stages-1];

  always_comb begin
    act = ACT_HOLD;
    if (tick) begin
      if (s && (cnt_q < CNT_MAX)) begin
        act = ACT_UP;
      end else if (!s && (cnt_q != '0)) begin
        act = ACT_DOWN;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case (act)
      ACT_UP:   cnt_d = cnt_q + 1'b1;
      ACT_DOWN: cnt_d = cnt_q - 1'b1;
      default:  cnt_d = cnt_q;
    endcase
  end

  // Level only moves at the saturation points; in between it holds.
  always_comb begin
    level_d = level_q;
    if (cnt_d == CNT_MAX) begin
      level_d = 1'b1;
    end else if (cnt_d == '0) begin
      level_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[sync_stages-2:0], glitchy_signal};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign debounced_signal = level_q;
  assign rise_pulse       = rise_q;
  assign fall_pulse       = fall_q;

endmodule

// File: rtl/edge_debouncer.sv
// Multi-channel debouncer: a shared sample-tick prescaler feeding one
// independent debounce_channel per input bit.
module edge_debouncer
  import edge_debouncer_pkg::*;
#(
  parameter int unsigned width                    = 1,
  parameter int unsigned sample_count_max         = 25000,
  parameter int unsigned pulse_count_max          = 150,
  parameter int unsigned sync_stages              = 2,
  parameter int unsigned wrapping_counter_width   = cnt_width(sample_count_max),
  parameter int unsigned saturating_counter_width = cnt_width(pulse_count_max + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] glitchy_signal,
  output logic [width-1:0] debounced_signal,
  output logic [width-1:0] rise_pulse,
  output logic [width-1:0] fall_pulse
);

  localparam logic [wrapping_counter_width-1:0] PRESC_LAST =
    wrapping_counter_width'(sample_count_max - 1);

  logic [wrapping_counter_width-1:0] presc_q, presc_d;
  logic                              tick;

  // With sample_count_max == 1 the counter sits at 0 and ticks every cycle.
  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < width; i++) begin : g_ch
    debounce_channel #(
      .pulse_count_max         (pulse_count_max),
      .sync_stages             (sync_stages),
      .saturating_counter_width(saturating_counter_width)
    ) u_ch (
      .clk             (clk),
      .rst_n           (rst_n),
      .tick            (tick),
      .glitchy_signal  (glitchy_signal[i]),
      .debounced_signal(debounced_signal[i]),
      .rise_pulse      (rise_pulse[i]),
      .fall_pulse      (fall_pulse[i])
    );
  end

endmodule
